// File: rtl/dmem_access_unit_pkg.sv
// Shared types and constants for the data-memory access unit.
package dmem_access_unit_pkg;

  localparam int NUM_LANES      = 4;
  localparam int DEF_BANK_DEPTH = 32768;

  // Access size encodings on req_size
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_e;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } state_e;

  // Number of bytes touched by an access of the given size (illegal size maps to 4)
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// CPU-side request/response channel of the data-memory access unit.
interface dmem_access_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Requester (CPU) side
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Access unit side
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_map.sv
// Combinational byte-lane mapping: for an address/size it yields which lanes
// are touched, each lane's bank index and write byte, and which lane holds
// each access byte for read-data alignment.
module dmem_lane_map
  import dmem_access_unit_pkg::*;
(
  input  logic [31:0]             addr,
  input  logic [1:0]              size,
  input  logic [31:0]             wdata,
  output logic [NUM_LANES-1:0]    lane_used,
  output logic [32*NUM_LANES-1:0] lane_idx,
  output logic [8*NUM_LANES-1:0]  lane_wdata,
  output logic [2*NUM_LANES-1:0]  rd_sel
);

  logic [2:0] nbytes;
  assign nbytes = size_nbytes(size);

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    // Offset within the access of the byte that falls on this lane
    logic [1:0] boff;
    assign boff = 2'(gi) - addr[1:0];

    assign lane_used[gi] = ({1'b0, boff} < nbytes);
    // Each lane is indexed on its own, so word-crossing accesses need one bank cycle
    assign lane_idx[32*gi +: 32] = lane_used[gi] ? ((addr + {30'd0, boff}) >> 2) : (addr >> 2);
    assign lane_wdata[8*gi +: 8] = wdata[8*boff +: 8];
    // Lane that supplies access byte gi on a read
    assign rd_sel[2*gi +: 2] = 2'(gi) + addr[1:0];
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Initiator for the four byte-banked data RAMs: accepts one load/store at a
// time, steers bytes to lanes, aligns/extends registered read data and
// returns a single response (with error for illegal accesses).
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int BANK_DEPTH = DEF_BANK_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dmem_access_unit_if.slave       bus,
  output logic [NUM_LANES-1:0]    bank_we,
  output logic [32*NUM_LANES-1:0] bank_idx,
  output logic [8*NUM_LANES-1:0]  bank_wdata,
  input  logic [8*NUM_LANES-1:0]  bank_rdata
);

  // Full 33-bit bound so addresses near 2^32 cannot wrap into range
  localparam logic [32:0] MEM_BYTES = 33'(64'(BANK_DEPTH) * 64'd4);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        store_fire;

  logic                    accept;
  logic                    req_err;
  logic [31:0]             map_addr;
  logic [1:0]              map_size;
  logic [NUM_LANES-1:0]    map_used;
  logic [2*NUM_LANES-1:0]  map_sel;
  logic [31:0]             load_raw;
  logic [31:0]             load_ext;

  // While idle the banks follow the live request; afterwards the captured one
  assign map_addr = (state_q == ST_IDLE) ? bus.req_addr : addr_q;
  assign map_size = (state_q == ST_IDLE) ? bus.req_size : size_q;

  dmem_lane_map u_lane_map (
    .addr       (map_addr),
    .size       (map_size),
    .wdata      (bus.req_wdata),
    .lane_used  (map_used),
    .lane_idx   (bank_idx),
    .lane_wdata (bank_wdata),
    .rd_sel     (map_sel)
  );

  assign bus.req_ready = rst_n && (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign accept        = bus.req_valid && bus.req_ready;
  assign req_err       = (bus.req_size == SZ_X) ||
                         (({1'b0, bus.req_addr} + {30'd0, size_nbytes(bus.req_size)}) > MEM_BYTES);
  // Writes only on a legal store accept, never while reset is asserted
  assign bank_we       = (store_fire && rst_n) ? map_used : '0;

  // Gather access bytes from their lanes (right-justified)
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_align
    assign load_raw[8*gi +: 8] = bank_rdata[8*map_sel[2*gi +: 2] +: 8];
  end

  // Sign/zero extension from the top bit of the accessed bytes
  always_comb begin
    load_ext = load_raw;
    case (size_q)
      SZ_B:    load_ext = {{24{~uns_q & load_raw[7]}},  load_raw[7:0]};
      SZ_H:    load_ext = {{16{~uns_q & load_raw[15]}}, load_raw[15:0]};
      default: load_ext = load_raw;
    endcase
  end

  // Next-state, request capture and response data
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    store_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d = bus.req_addr;
          size_d = bus.req_size;
          uns_d  = bus.req_unsigned;
          if (req_err) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = ST_RESP;
          end else if (bus.req_we) begin
            store_fire = 1'b1;
            err_d      = 1'b0;
            rdata_d    = '0;
            state_d    = ST_RESP;
          end else begin
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        rdata_d = load_ext;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and captured-request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed cases plus randomized traffic checked
// against a flat byte-array memory model.
module tb_dmem_access_unit;
  import dmem_access_unit_pkg::*;

  localparam int BANK_DEPTH = 32768;
  localparam int MEM_BYTES  = 4 * BANK_DEPTH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   bank_we;
  logic [127:0] bank_idx;
  logic [31:0]  bank_wdata;
  logic [31:0]  bank_rdata;

  dmem_access_unit_if bus();

  dmem_access_unit #(.BANK_DEPTH(BANK_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .bank_we    (bank_we),
    .bank_idx   (bank_idx),
    .bank_wdata (bank_wdata),
    .bank_rdata (bank_rdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Four byte-wide bank RAMs with registered read (environment, not a reference)
  bit [7:0] bank_mem [4][BANK_DEPTH];
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      bank_rdata[8*k +: 8] <= bank_mem[k][bank_idx[32*k +: 15]];
      if (bank_we[k]) bank_mem[k][bank_idx[32*k +: 15]] <= bank_wdata[8*k +: 8];
    end
  end

  // Reference: flat byte-addressed memory
  bit [7:0] ref_mem [MEM_BYTES];

  // Current transaction
  logic        t_we, t_uns, t_err;
  logic [1:0]  t_sz;
  logic [31:0] t_a, t_wd, t_exp_rd;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes_of(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (longint'(a) + longint'(nbytes_of(sz)) > longint'(MEM_BYTES));
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = nbytes_of(sz);
    v = '0;
    for (int b = 0; b < n; b++) v[8*b +: 8] = ref_mem[int'(a) + b];
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
    return v;
  endfunction

  // Which lanes an access touches, with per-lane index and write byte
  task automatic exp_lanes(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                           output logic [3:0] used, output logic [127:0] idx,
                           output logic [31:0] wb, output logic [31:0] bmask);
    int n;
    int lane;
    logic [31:0] ab;
    n = nbytes_of(sz);
    used = '0; wb = '0; bmask = '0;
    for (int k = 0; k < 4; k++) idx[32*k +: 32] = a >> 2;
    for (int b = 0; b < n; b++) begin
      ab = a + 32'(b);
      lane = int'(ab % 4);
      used[lane] = 1'b1;
      idx[32*lane +: 32] = ab >> 2;
      wb[8*lane +: 8] = wd[8*b +: 8];
      bmask[8*lane +: 8] = 8'hFF;
    end
  endtask

  // Drive a request at the negedge and check the combinational bank outputs
  task automatic present_req(input logic we, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd);
    logic [3:0] used;
    logic [127:0] eidx;
    logic [31:0] ewb, bmask;
    t_we = we; t_sz = sz; t_uns = uns; t_a = a; t_wd = wd;
    t_err = is_err(sz, a);
    t_exp_rd = (t_err || we) ? 32'h0 : ref_load(sz, uns, a);
    exp_lanes(sz, a, wd, used, eidx, ewb, bmask);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
    #1;
    check("req_ready_idle", bus.req_ready, 1'b1);
    check("bank_we", bank_we, (t_err || !we) ? 4'h0 : used);
    if (!t_err) check("bank_idx", bank_idx, eidx);
    if (we && !t_err) check("bank_wdata", bank_wdata & bmask, ewb);
  endtask

  // Accept edge, latency, response, optional back-pressure, handshake
  task automatic complete_txn(input int stall, output logic [31:0] rd, output logic er);
    int lat;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (t_we && !t_err)
      for (int b = 0; b < nbytes_of(t_sz); b++) ref_mem[int'(t_a) + b] = t_wd[8*b +: 8];
    lat = 1;
    while (!bus.rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, (t_we || t_err) ? 1 : 2);
    check("rsp_err", bus.rsp_err, t_err);
    check("rsp_rdata", bus.rsp_rdata, t_exp_rd);
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", bus.rsp_valid, 1'b1);
      check("stall_ready", bus.req_ready, 1'b0);
      check("stall_rdata", bus.rsp_rdata, t_exp_rd);
      check("stall_err", bus.rsp_err, t_err);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("rsp_valid_drop", bus.rsp_valid, 1'b0);
    check("back_to_idle", bus.req_ready, 1'b1);
    $display("txn we=%0d size=%0d uns=%0d addr=%08h wdata=%08h -> rdata=%08h err=%0d",
             t_we, t_sz, t_uns, t_a, t_wd, rd, er);
    @(negedge clk);
  endtask

  task automatic run_txn(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input int stall,
                         output logic [31:0] rd, output logic er);
    present_req(we, sz, uns, a, wd);
    complete_txn(stall, rd, er);
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic er;
    logic [31:0] a, wd;
    logic [1:0] sz;
    int r;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset_rsp_err", bus.rsp_err, 1'b0);
    check("reset_req_ready", bus.req_ready, 1'b1);
    check("reset_bank_we", bank_we, 4'h0);

    // Aligned word store
    present_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    check("t1_we", bank_we, 4'hF);
    check("t1_idx", bank_idx, {4{32'h40}});
    check("t1_wdata", bank_wdata, 32'hDEADBEEF);
    complete_txn(0, rd, er);

    // Byte/half loads with extension
    run_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, rd, er);
    check("t2_lb", rd, 32'hFFFFFFDE);
    run_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, rd, er);
    check("t2_lbu", rd, 32'h000000DE);
    run_txn(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 0, rd, er);
    check("t2_lh", rd, 32'hFFFFDEAD);

    // Word-crossing store and load
    present_req(1'b1, 2'd2, 1'b0, 32'h0FE, 32'h11223344);
    check("t3_we", bank_we, 4'hF);
    check("t3_idx", bank_idx, {32'h3F, 32'h3F, 32'h40, 32'h40});
    check("t3_wdata", bank_wdata, 32'h33441122);
    complete_txn(0, rd, er);
    run_txn(1'b0, 2'd2, 1'b0, 32'h0FE, 32'h0, 0, rd, er);
    check("t3_lw", rd, 32'h11223344);

    // Illegal accesses
    run_txn(1'b0, 2'd2, 1'b0, 32'(MEM_BYTES - 2), 32'h0, 0, rd, er);
    check("t4_oob_err", er, 1'b1);
    check("t4_oob_rdata", rd, 32'h0);
    run_txn(1'b1, 2'd3, 1'b0, 32'h0, 32'hFFFFFFFF, 0, rd, er);
    check("t4_sz3_err", er, 1'b1);
    run_txn(1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h1234, 0, rd, er);
    check("t4_wrap_err", er, 1'b1);
    run_txn(1'b0, 2'd0, 1'b1, 32'(MEM_BYTES - 1), 32'h0, 0, rd, er);
    check("t4_last_byte_ok", er, 1'b0);

    // Back-pressure
    run_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5, rd, er);

    // Reset during RD_WAIT
    run_txn(1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFEF00D, 0, rd, er);
    present_req(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
    bus.req_addr = 32'h300; bus.req_wdata = 32'h0BADBEEF;
    rst_n = 1'b0;
    #1;
    check("t6_valid_in_reset", bus.rsp_valid, 1'b0);
    check("t6_we_in_reset", bank_we, 4'h0);
    @(posedge clk); #1;
    check("t6_we_in_reset2", bank_we, 4'h0);
    check("t6_rdata_in_reset", bus.rsp_rdata, 32'h0);
    check("t6_err_in_reset", bus.rsp_err, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_valid_after", bus.rsp_valid, 1'b0);
    run_txn(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 0, rd, er);
    check("t6_unwritten", rd, 32'hCAFEF00D);
    run_txn(1'b1, 2'd1, 1'b0, 32'h305, 32'h0000A55A, 0, rd, er);
    run_txn(1'b0, 2'd1, 1'b0, 32'h305, 32'h0, 0, rd, er);
    check("t6_pair", rd, 32'hFFFFA55A);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)      a = 32'h200 + 32'($urandom_range(0, 63));
      else if (r < 9) a = 32'(MEM_BYTES) - 32'($urandom_range(1, 6));
      else            a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      wd = $urandom;
      run_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, wd,
              int'($urandom_range(0, 3)), rd, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
